// File: rtl/sm3_expnd_core.sv
// Purpose: SM3 message expansion; loads a 512-bit block as beats, emits (Wj, W'j) for j=0..63.
// Latency: first round is presented the cycle after the last beat is accepted; 64 contiguous rounds.
// Backpressure: ready only while loading; output side has no backpressure.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   pad_otpt_dt_i       - padded message beat (INPT_DW bits, upper word is the earlier word)
//   pad_otpt_vld_i      - beat valid
//   pad_otpt_lst_i      - beat belongs to the final block of the message
//   expnd_inpt_rdy_o    - stage accepts a beat (LOAD state)
//   expnd_otpt_wj_o     - Wj
//   expnd_otpt_wjj_o    - W'j = Wj ^ Wj+4
//   expnd_otpt_lst_o    - round 63 of the final block
//   expnd_otpt_vld_o    - wj/wjj valid
module sm3_expnd_core #(
    parameter int INPT_DW = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INPT_DW-1:0] pad_otpt_dt_i,
    input  logic               pad_otpt_vld_i,
    input  logic               pad_otpt_lst_i,
    output logic               expnd_inpt_rdy_o,
    output logic [31:0]        expnd_otpt_wj_o,
    output logic [31:0]        expnd_otpt_wjj_o,
    output logic               expnd_otpt_lst_o,
    output logic               expnd_otpt_vld_o
);

    localparam int BPB = 512 / INPT_DW;
    localparam int WPB = INPT_DW / 32;
    localparam int BCW = $clog2(BPB);

    typedef enum logic {
        LOAD  = 1'b0,
        EXPND = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BCW-1:0]  r_bcnt;
    logic [5:0]      r_rcnt;
    logic [31:0]     r_win [0:15];
    logic            r_lst_flag;

    logic            w_xfer;
    logic            w_bcnt_last;
    logic            w_rcnt_last;
    logic [31:0]     w_wn;

    function automatic logic [31:0] rotl7(input logic [31:0] x);
        return {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] rotl15(input logic [31:0] x);
        return {x[16:0], x[31:17]};
    endfunction

    function automatic logic [31:0] rotl23(input logic [31:0] x);
        return {x[8:0], x[31:9]};
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl15(x) ^ rotl23(x);
    endfunction

    assign expnd_inpt_rdy_o = (r_state == LOAD);
    assign w_xfer           = pad_otpt_vld_i && expnd_inpt_rdy_o;
    assign w_bcnt_last      = (r_bcnt == BCW'(BPB - 1));
    assign w_rcnt_last      = (r_rcnt == 6'd63);

    // Next word of the expansion, taken from the current 16-word window:
    // W[0]=Wj-16, W[3]=Wj-13, W[7]=Wj-9, W[10]=Wj-6, W[13]=Wj-3.
    assign w_wn = p1(r_win[0] ^ r_win[7] ^ rotl15(r_win[13])) ^ rotl7(r_win[3]) ^ r_win[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus output decode. Outputs depend only on registered
    // state, so there is no combinational path from the input beat.
    always_comb begin
        w_state_nxt      = r_state;
        expnd_otpt_vld_o = 1'b0;
        expnd_otpt_wj_o  = 32'd0;
        expnd_otpt_wjj_o = 32'd0;
        expnd_otpt_lst_o = 1'b0;
        case (r_state)
            LOAD: begin
                if (w_xfer && w_bcnt_last) begin
                    w_state_nxt = EXPND;
                end
            end
            EXPND: begin
                expnd_otpt_vld_o = 1'b1;
                expnd_otpt_wj_o  = r_win[0];
                expnd_otpt_wjj_o = r_win[0] ^ r_win[4];
                expnd_otpt_lst_o = r_lst_flag && w_rcnt_last;
                if (w_rcnt_last) begin
                    w_state_nxt = LOAD;
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcnt     <= '0;
            r_rcnt     <= '0;
            r_lst_flag <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= 32'd0;
            end
        end else if (r_state == LOAD) begin
            if (w_xfer) begin
                // Shift WPB words into the tail; after BPB beats word 0 sits in W[0].
                for (int i = 0; i < 16 - WPB; i++) begin
                    r_win[i] <= r_win[i + WPB];
                end
                for (int k = 0; k < WPB; k++) begin
                    r_win[16 - WPB + k] <= pad_otpt_dt_i[INPT_DW - 1 - 32 * k -: 32];
                end
                r_lst_flag <= r_lst_flag | pad_otpt_lst_i;
                if (w_bcnt_last) begin
                    r_bcnt <= '0;
                    r_rcnt <= 6'd0;
                end else begin
                    r_bcnt <= r_bcnt + BCW'(1);
                end
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                r_win[i] <= r_win[i + 1];
            end
            r_win[15] <= w_wn;
            r_rcnt    <= r_rcnt + 6'd1;
            // Clearing here keeps a final-block mark from leaking into the next block.
            if (w_rcnt_last) begin
                r_lst_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sm3_expnd_core.sv
module tb_sm3_expnd_core;

    typedef logic [31:0] w16_t [16];
    typedef logic [31:0] w68_t [68];

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dt32;
    logic        vld32, lst32;
    logic        rdy32, olst32, ovld32;
    logic [31:0] wj32, wjj32;
    logic [63:0] dt64;
    logic        vld64, lst64;
    logic        rdy64, olst64, ovld64;
    logic [31:0] wj64, wjj64;

    always #5 clk = ~clk;

    sm3_expnd_core #(.INPT_DW(32)) u_dut32 (
        .clk              (clk),
        .rst              (rst),
        .pad_otpt_dt_i    (dt32),
        .pad_otpt_vld_i   (vld32),
        .pad_otpt_lst_i   (lst32),
        .expnd_inpt_rdy_o (rdy32),
        .expnd_otpt_wj_o  (wj32),
        .expnd_otpt_wjj_o (wjj32),
        .expnd_otpt_lst_o (olst32),
        .expnd_otpt_vld_o (ovld32)
    );

    sm3_expnd_core #(.INPT_DW(64)) u_dut64 (
        .clk              (clk),
        .rst              (rst),
        .pad_otpt_dt_i    (dt64),
        .pad_otpt_vld_i   (vld64),
        .pad_otpt_lst_i   (lst64),
        .expnd_inpt_rdy_o (rdy64),
        .expnd_otpt_wj_o  (wj64),
        .expnd_otpt_wjj_o (wjj64),
        .expnd_otpt_lst_o (olst64),
        .expnd_otpt_vld_o (ovld64)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rdy_lo32 = 0;
    int idle_bad = 0;

    logic [31:0] q_wj32[$], q_wjj32[$], q_wj64[$], q_wjj64[$];
    logic        q_lst32[$], q_lst64[$];
    int          q_cyc32[$], q_cyc64[$];

    w16_t msg_abc, msg_b;
    w68_t exp_abc, exp_b;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (ovld32) begin
            q_wj32.push_back(wj32);
            q_wjj32.push_back(wjj32);
            q_lst32.push_back(olst32);
            q_cyc32.push_back(cyc);
        end else if (wj32 != 32'd0 || wjj32 != 32'd0 || olst32) begin
            idle_bad++;
        end
        if (ovld64) begin
            q_wj64.push_back(wj64);
            q_wjj64.push_back(wjj64);
            q_lst64.push_back(olst64);
            q_cyc64.push_back(cyc);
        end else if (wj64 != 32'd0 || wjj64 != 32'd0 || olst64) begin
            idle_bad++;
        end
        if (!rdy32) rdy_lo32++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] mp1(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    // Reference expansion from the standard indexed recurrence.
    task automatic gen_exp(input w16_t m, output w68_t e);
        for (int j = 0; j < 16; j++) e[j] = m[j];
        for (int j = 16; j < 68; j++)
            e[j] = mp1(e[j-16] ^ e[j-9] ^ rotl(e[j-3], 15)) ^ rotl(e[j-13], 7) ^ e[j-6];
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic clr;
        q_wj32.delete(); q_wjj32.delete(); q_lst32.delete(); q_cyc32.delete();
        q_wj64.delete(); q_wjj64.delete(); q_lst64.delete(); q_cyc64.delete();
    endtask

    task automatic drop;
        tick;
        vld32 = 1'b0; lst32 = 1'b0; dt32 = 32'hA5A5A5A5;
        vld64 = 1'b0; lst64 = 1'b0; dt64 = 64'h5A5A5A5A5A5A5A5A;
    endtask

    // Sends nbeats beats of m, holding each until accepted. lst_beat<0 means none.
    task automatic send_block(input bit s64, input w16_t m, input int lst_beat,
                              input bit bubbly, input int nbeats, output int acc_cyc);
        bit done;
        int guard;
        acc_cyc = -1;
        for (int b = 0; b < nbeats; b++) begin
            if (bubbly) begin
                tick;
                vld32 = 1'b0; dt32 = 32'hDEADBEEF; lst32 = 1'b1;
                vld64 = 1'b0; dt64 = 64'hDEADBEEFDEADBEEF; lst64 = 1'b1;
            end
            done = 1'b0;
            guard = 0;
            while (!done) begin
                tick;
                if (s64) begin
                    vld64 = 1'b1; dt64 = {m[2*b], m[2*b+1]}; lst64 = (b == lst_beat);
                    done = rdy64;
                end else begin
                    vld32 = 1'b1; dt32 = m[b]; lst32 = (b == lst_beat);
                    done = rdy32;
                end
                if (done) acc_cyc = cyc;
                guard++;
                if (!done && guard > 300) begin
                    chk("drv_timeout", 32'd1, 32'd0);
                    done = 1'b1;
                end
            end
        end
    endtask

    function automatic int qsize(input bit s64);
        return s64 ? q_wj64.size() : q_wj32.size();
    endfunction

    task automatic wait_outputs(input bit s64, input int n, input string tag);
        int g;
        g = 0;
        while (qsize(s64) < n && g < 400) begin
            tick;
            g++;
        end
        repeat (4) tick;
        chk({tag, "_count"}, qsize(s64), n);
    endtask

    task automatic check_stream(input bit s64, input string tag, input int base,
                                input w68_t e, input bit lst_exp);
        logic [31:0] wj, wjj;
        logic        l;
        int          c0, c63;
        if (qsize(s64) < base + 64) begin
            chk({tag, "_short"}, qsize(s64), base + 64);
            return;
        end
        for (int j = 0; j < 64; j++) begin
            wj  = s64 ? q_wj64[base+j]  : q_wj32[base+j];
            wjj = s64 ? q_wjj64[base+j] : q_wjj32[base+j];
            l   = s64 ? q_lst64[base+j] : q_lst32[base+j];
            chk($sformatf("%s_wj%0d", tag, j), wj, e[j]);
            chk($sformatf("%s_wjj%0d", tag, j), wjj, e[j] ^ e[j+4]);
            chk($sformatf("%s_lst%0d", tag, j), {31'd0, l}, {31'd0, lst_exp && (j == 63)});
        end
        c0  = s64 ? q_cyc64[base]    : q_cyc32[base];
        c63 = s64 ? q_cyc64[base+63] : q_cyc32[base+63];
        chk({tag, "_contig"}, c63 - c0, 32'd63);
    endtask

    initial begin
        int acc, acc2, g;

        for (int i = 0; i < 16; i++) begin
            msg_abc[i] = 32'd0;
            msg_b[i]   = 32'h9E3779B9 ^ (i * 32'h01030507) ^ (32'h80000000 >> i);
        end
        msg_abc[0]  = 32'h61626380;
        msg_abc[15] = 32'h00000018;
        gen_exp(msg_abc, exp_abc);
        gen_exp(msg_b, exp_b);

        rst = 1'b1;
        vld32 = 1'b0; lst32 = 1'b0; dt32 = 32'd0;
        vld64 = 1'b0; lst64 = 1'b0; dt64 = 64'd0;
        repeat (3) tick;
        rst = 1'b0;
        tick;
        chk("rst_rdy32", {31'd0, rdy32}, 32'd1);
        chk("rst_vld32", {31'd0, ovld32}, 32'd0);
        chk("rst_wj32", wj32, 32'd0);
        chk("rst_wjj32", wjj32, 32'd0);
        chk("rst_lst32", {31'd0, olst32}, 32'd0);
        chk("rst_rdy64", {31'd0, rdy64}, 32'd1);
        chk("rst_vld64", {31'd0, ovld64}, 32'd0);

        // abc, 32-bit beats, contiguous
        clr;
        send_block(1'b0, msg_abc, 15, 1'b0, 16, acc);
        drop;
        wait_outputs(1'b0, 64, "t1");
        if (q_wj32.size() >= 64) begin
            chk("t1_first_cyc", q_cyc32[0], acc + 1);
            chk("t1_w0",  q_wj32[0],  32'h61626380);
            chk("t1_w16", q_wj32[16], 32'h9092e200);
            chk("t1_w17", q_wj32[17], 32'h00000000);
            chk("t1_w18", q_wj32[18], 32'h000c0606);
            chk("t1_w19", q_wj32[19], 32'h719c70ed);
            chk("t1_w20", q_wj32[20], 32'h00000000);
            chk("t1_w21", q_wj32[21], 32'h8001801f);
            chk("t1_wjj0",  q_wjj32[0],  32'h61626380);
            chk("t1_wjj12", q_wjj32[12], 32'h9092e200);
            chk("t1_wjj15", q_wjj32[15], 32'h719c70f5);
        end
        check_stream(1'b0, "t1", 0, exp_abc, 1'b1);

        // abc, 64-bit beats
        clr;
        send_block(1'b1, msg_abc, 7, 1'b0, 8, acc);
        drop;
        wait_outputs(1'b1, 64, "t2");
        if (q_wj64.size() >= 64) begin
            chk("t2_first_cyc", q_cyc64[0], acc + 1);
            chk("t2_w16", q_wj64[16], 32'h9092e200);
            chk("t2_wjj15", q_wjj64[15], 32'h719c70f5);
        end
        check_stream(1'b1, "t2", 0, exp_abc, 1'b1);

        // back-to-back, vld held high, lst only on block 2
        clr;
        rdy_lo32 = 0;
        send_block(1'b0, msg_b, -1, 1'b0, 16, acc);
        send_block(1'b0, msg_abc, 15, 1'b0, 16, acc2);
        drop;
        wait_outputs(1'b0, 128, "t3");
        if (q_wj32.size() >= 128) begin
            chk("t3_gap", q_cyc32[64] - q_cyc32[63], 32'd17);
            chk("t3_first2", q_cyc32[64], acc2 + 1);
        end
        chk("t3_rdy_lo", rdy_lo32, 32'd128);
        check_stream(1'b0, "t3a", 0, exp_b, 1'b0);
        check_stream(1'b0, "t3b", 64, exp_abc, 1'b1);

        // bubbly load (garbage lst on idle cycles)
        clr;
        send_block(1'b0, msg_abc, 15, 1'b1, 16, acc);
        drop;
        wait_outputs(1'b0, 64, "t4");
        if (q_wj32.size() >= 64) chk("t4_first_cyc", q_cyc32[0], acc + 1);
        check_stream(1'b0, "t4", 0, exp_abc, 1'b1);

        // reset at round 30
        clr;
        send_block(1'b0, msg_b, 15, 1'b0, 16, acc);
        drop;
        g = 0;
        while (q_wj32.size() < 31 && g < 200) begin
            tick;
            g++;
        end
        chk("t5_reached_r30", q_wj32.size(), 32'd31);
        rst = 1'b1;
        tick;
        chk("t5_vld", {31'd0, ovld32}, 32'd0);
        chk("t5_lst", {31'd0, olst32}, 32'd0);
        chk("t5_wj", wj32, 32'd0);
        chk("t5_rdy", {31'd0, rdy32}, 32'd1);
        rst = 1'b0;
        clr;
        send_block(1'b0, msg_abc, 15, 1'b0, 16, acc);
        drop;
        wait_outputs(1'b0, 64, "t5");
        if (q_wj32.size() >= 64) chk("t5_first_cyc", q_cyc32[0], acc + 1);
        check_stream(1'b0, "t5", 0, exp_abc, 1'b1);

        // reset during a partial load that carried lst
        clr;
        send_block(1'b0, msg_b, 2, 1'b0, 5, acc);
        drop;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        send_block(1'b0, msg_abc, -1, 1'b0, 16, acc);
        drop;
        wait_outputs(1'b0, 64, "t6");
        check_stream(1'b0, "t6", 0, exp_abc, 1'b0);

        // lst on beat 5, next block without lst
        clr;
        send_block(1'b0, msg_b, 5, 1'b0, 16, acc);
        send_block(1'b0, msg_abc, -1, 1'b0, 16, acc2);
        drop;
        wait_outputs(1'b0, 128, "t7");
        check_stream(1'b0, "t7a", 0, exp_b, 1'b1);
        check_stream(1'b0, "t7b", 64, exp_abc, 1'b0);

        chk("idle_outputs_zero", idle_bad, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
